// File: rtl/freqdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : freqdiv_pkg                                                   |
// | Brief    : Shared defaults, edge-event encoding and divisor helpers for  |
// |            the programmable frequency divider (freqdiv_prog).            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package freqdiv_pkg;

  localparam int unsigned C_W_DEF   = 26;
  localparam int unsigned C_DIV_DEF = 50_000_000;
  localparam int unsigned C_HI_DEF  = 0;

  // Helpers operate on a fixed 32-bit word; callers cast to/from their own W.
  localparam int unsigned C_FN_W = 32;
  typedef logic [C_FN_W-1:0] fd_word_t;

  // What the counter does on the coming clock edge.
  typedef enum logic [1:0] {
    EV_HOLD  = 2'd0,
    EV_COUNT = 2'd1,
    EV_WRAP  = 2'd2,
    EV_CLEAR = 2'd3
  } fd_event_e;

  function automatic fd_word_t clamp_div(input fd_word_t div);
    fd_word_t res;
    res = (div == '0) ? fd_word_t'(1) : div;
    return res;
  endfunction

  function automatic fd_word_t ceil_half(input fd_word_t div);
    fd_word_t res;
    res = div - (div >> 1);
    return res;
  endfunction

  // High time for a clamped divisor; zero duty (or duty disabled) means ceil(div/2).
  function automatic fd_word_t hi_time(input fd_word_t div, input fd_word_t duty,
                                       input logic duty_en);
    fd_word_t res;
    if (!duty_en || (duty == '0)) begin
      res = ceil_half(div);
    end else if (duty > div) begin
      res = div;
    end else begin
      res = duty;
    end
    return res;
  endfunction

endpackage : freqdiv_pkg
`default_nettype wire

// File: rtl/freqdiv_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : freqdiv_shadow                                                |
// | Brief    : Double-buffered divisor/high-time registers. Loads land in a  |
// |            shadow and move to the active set only on a period boundary.  |
// |            FREQDIV_DUTY_EN adds the i_duty_in high-time input.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module freqdiv_shadow
  import freqdiv_pkg::*;
#(
  parameter int unsigned W           = C_W_DEF,
  parameter int unsigned DEFAULT_DIV = C_DIV_DEF,
  parameter int unsigned DEFAULT_HI  = C_HI_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_apply,
  input  logic         i_div_load,
  input  logic [W-1:0] i_div_in,
`ifdef FREQDIV_DUTY_EN
  input  logic [W-1:0] i_duty_in,
`endif
  output logic [W-1:0] o_div_act,
  output logic [W-1:0] o_hi_nxt,
  output logic         o_load_pending
);

`ifdef FREQDIV_DUTY_EN
  localparam logic c_duty_en = 1'b1;
`else
  localparam logic c_duty_en = 1'b0;
`endif

  localparam fd_word_t     c_div_rst_w = clamp_div(fd_word_t'(DEFAULT_DIV));
  localparam fd_word_t     c_hi_rst_w  = hi_time(c_div_rst_w, fd_word_t'(DEFAULT_HI), c_duty_en);
  localparam logic [W-1:0] c_div_rst   = W'(c_div_rst_w);
  localparam logic [W-1:0] c_hi_rst    = W'(c_hi_rst_w);

  logic [W-1:0] r_sh_div;
  logic [W-1:0] r_sh_hi;
  logic [W-1:0] r_div_act;
  logic [W-1:0] r_hi_act;
  logic         r_pending;

  logic [W-1:0] w_new_div;
  logic [W-1:0] w_new_hi;
  logic [W-1:0] w_src_div;
  logic [W-1:0] w_src_hi;
  logic [W-1:0] w_div_nxt;
  logic [W-1:0] w_hi_nxt;
  logic         w_take;

  always_comb begin
    w_new_div = W'(clamp_div(fd_word_t'(i_div_in)));
`ifdef FREQDIV_DUTY_EN
    w_new_hi  = W'(hi_time(fd_word_t'(w_new_div), fd_word_t'(i_duty_in), c_duty_en));
`else
    w_new_hi  = W'(hi_time(fd_word_t'(w_new_div), '0, c_duty_en));
`endif
    // A load arriving on the boundary edge itself bypasses the shadow.
    w_src_div = i_div_load ? w_new_div : r_sh_div;
    w_src_hi  = i_div_load ? w_new_hi  : r_sh_hi;
    w_take    = i_apply & (i_div_load | r_pending);
    w_div_nxt = w_take ? w_src_div : r_div_act;
    w_hi_nxt  = w_take ? w_src_hi  : r_hi_act;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_div  <= c_div_rst;
      r_sh_hi   <= c_hi_rst;
      r_div_act <= c_div_rst;
      r_hi_act  <= c_hi_rst;
      r_pending <= 1'b0;
    end else begin
      if (i_div_load) begin
        r_sh_div <= w_new_div;
        r_sh_hi  <= w_new_hi;
      end
      if (i_apply) begin
        r_pending <= 1'b0;
      end else if (i_div_load) begin
        r_pending <= 1'b1;
      end
      r_div_act <= w_div_nxt;
      r_hi_act  <= w_hi_nxt;
    end
  end

  assign o_div_act      = r_div_act;
  assign o_hi_nxt       = w_hi_nxt;
  assign o_load_pending = r_pending;

endmodule : freqdiv_shadow
`default_nettype wire

// File: rtl/freqdiv_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : freqdiv_prog                                                  |
// | Brief    : Runtime-programmable clock divider: 1-cycle tick per period   |
// |            plus a square-wave clk_out. Define FREQDIV_DUTY_EN to add the |
// |            duty_in high-time port.                                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module freqdiv_prog
  import freqdiv_pkg::*;
#(
  parameter int unsigned W           = C_W_DEF,
  parameter int unsigned DEFAULT_DIV = C_DIV_DEF,
  parameter int unsigned DEFAULT_HI  = C_HI_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync_clr,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
`ifdef FREQDIV_DUTY_EN
  input  logic [W-1:0] duty_in,
`endif
  output logic         tick,
  output logic         clk_out,
  output logic         load_pending
);

  localparam logic [W-1:0] c_one = W'(1);

  fd_event_e    w_ev;
  logic         w_apply;
  logic [W-1:0] w_div_act;
  logic [W-1:0] w_hi_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic         w_tick_nxt;
  logic         w_clk_nxt;

  logic [W-1:0] r_cnt;
  logic         r_tick;
  logic         r_clk_out;

  freqdiv_shadow #(
    .W           (W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .DEFAULT_HI  (DEFAULT_HI)
  ) u_shadow (
    .clk            (clk),
    .rst            (rst),
    .i_apply        (w_apply),
    .i_div_load     (div_load),
    .i_div_in       (div_in),
`ifdef FREQDIV_DUTY_EN
    .i_duty_in      (duty_in),
`endif
    .o_div_act      (w_div_act),
    .o_hi_nxt       (w_hi_nxt),
    .o_load_pending (load_pending)
  );

  // sync_clr outranks everything, including a disabled counter.
  always_comb begin
    if (sync_clr) begin
      w_ev = EV_CLEAR;
    end else if (!en) begin
      w_ev = EV_HOLD;
    end else if (r_cnt == (w_div_act - c_one)) begin
      w_ev = EV_WRAP;
    end else begin
      w_ev = EV_COUNT;
    end
    w_apply = (w_ev == EV_CLEAR) || (w_ev == EV_WRAP);
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_tick_nxt = 1'b0;
    case (w_ev)
      EV_CLEAR: w_cnt_nxt = '0;
      EV_WRAP: begin
        w_cnt_nxt  = '0;
        w_tick_nxt = 1'b1;
      end
      EV_COUNT: w_cnt_nxt = r_cnt + c_one;
      default:  w_cnt_nxt = r_cnt;
    endcase

    // clk_out tracks the position the counter is moving to, against the
    // high time that will be in force for that position.
    if (w_ev == EV_CLEAR) begin
      w_clk_nxt = 1'b1;
    end else if (w_ev == EV_HOLD) begin
      w_clk_nxt = r_clk_out;
    end else begin
      w_clk_nxt = (w_cnt_nxt < w_hi_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tick    <= w_tick_nxt;
      r_clk_out <= w_clk_nxt;
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;

endmodule : freqdiv_prog
`default_nettype wire

// File: tb/tb_freqdiv_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_freqdiv_prog                                               |
// | Brief    : Self-checking bench for freqdiv_prog (W=8, DEFAULT_DIV=4):    |
// |            directed scenarios with literal expectations, then random     |
// |            traffic against a period-level model. FREQDIV_DUTY_EN aware.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_freqdiv_prog;

  localparam int W    = 8;
  localparam int DDIV = 4;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic         sync_clr = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_in   = '0;
`ifdef FREQDIV_DUTY_EN
  logic [W-1:0] duty_in  = '0;
`endif
  logic         tick;
  logic         clk_out;
  logic         load_pending;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  freqdiv_prog #(
    .W           (W),
    .DEFAULT_DIV (DDIV),
    .DEFAULT_HI  (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sync_clr     (sync_clr),
    .div_in       (div_in),
    .div_load     (div_load),
`ifdef FREQDIV_DUTY_EN
    .duty_in      (duty_in),
`endif
    .tick         (tick),
    .clk_out      (clk_out),
    .load_pending (load_pending)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Period-level model: position inside the current period plus the active
  // and pending (divisor, high-time) pairs, all as plain integers.
  int m_pos  = 0;
  int m_div  = DDIV;
  int m_hi   = (DDIV + 1) / 2;
  int m_sdiv = DDIV;
  int m_shi  = (DDIV + 1) / 2;
  bit m_pend = 1'b0;
  bit m_tick = 1'b0;
  bit m_clk  = 1'b0;

  initial forever begin
    int nd;
    int nh;
    bit boundary;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pos  = 0;
      m_div  = DDIV;
      m_hi   = (DDIV + 1) / 2;
      m_pend = 1'b0;
      m_tick = 1'b0;
      m_clk  = 1'b0;
    end else begin
      nd = (div_in == '0) ? 1 : int'(div_in);
`ifdef FREQDIV_DUTY_EN
      nh = (duty_in == '0) ? (nd + 1) / 2 : ((int'(duty_in) > nd) ? nd : int'(duty_in));
`else
      nh = (nd + 1) / 2;
`endif
      if (div_load) begin
        m_sdiv = nd;
        m_shi  = nh;
      end
      boundary = sync_clr || (en && (m_pos + 1 == m_div));
      if (boundary) begin
        if (m_pend || div_load) begin
          m_div = m_sdiv;
          m_hi  = m_shi;
        end
        m_pend = 1'b0;
        m_pos  = 0;
        m_tick = !sync_clr;
        m_clk  = 1'b1;
      end else begin
        m_tick = 1'b0;
        if (div_load) m_pend = 1'b1;
        if (en) begin
          m_pos = m_pos + 1;
          m_clk = (m_pos < m_hi);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cmp_tick", 32'(tick), 32'(m_tick));
      chk("cmp_clk_out", 32'(clk_out), 32'(m_clk));
      chk("cmp_load_pending", 32'(load_pending), 32'(m_pend));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic collect(input int n, output logic [15:0] tv, output logic [15:0] cv);
    tv = '0;
    cv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tv[i] = tick;
      cv[i] = clk_out;
    end
  endtask

  initial begin
    logic [15:0] tv;
    logic [15:0] cv;

    adv(3);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_clk_out", 32'(clk_out), 0);
    chk("reset_load_pending", 32'(load_pending), 0);

    // Default divisor 4: ticks at edges 4/8/12, clk_out high for positions 0,1.
    rst    = 1'b0;
    chk_en = 1'b1;
    en     = 1'b1;
    collect(12, tv, cv);
    chk("t1_tick_edges", 32'(tv[11:0]), 32'h888);
    chk("t1_clk_out_edges", 32'(cv[11:0]), 32'h999);

    // Mid-period load of 5: the running period of 4 finishes first.
    adv(1);
    div_in   = 8'd5;
    div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("t2_pending_set", 32'(load_pending), 1);
    adv(1);
    chk("t2_old_period_no_tick", 32'(tick), 0);
    adv(1);
    chk("t2_old_period_tick", 32'(tick), 1);
    chk("t2_pending_cleared", 32'(load_pending), 0);
    collect(5, tv, cv);
    chk("t2_div5_tick", 32'(tv[4:0]), 32'b10000);
    chk("t2_div5_clk_out", 32'(cv[4:0]), 32'b10011);

    // Divisor 0 behaves as 1 once sync_clr applies it.
    div_in   = 8'd0;
    div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("t3_pending", 32'(load_pending), 1);
    sync_clr = 1'b1;
    adv(1);
    sync_clr = 1'b0;
    chk("t3_clr_tick", 32'(tick), 0);
    chk("t3_clr_clk_out", 32'(clk_out), 1);
    chk("t3_clr_pending", 32'(load_pending), 0);
    collect(4, tv, cv);
    chk("t3_div1_tick", 32'(tv[3:0]), 32'hF);
    chk("t3_div1_clk_out", 32'(cv[3:0]), 32'hF);

    // Load + sync_clr together applies 4 at once; then freeze at position 2.
    div_in   = 8'd4;
    div_load = 1'b1;
    sync_clr = 1'b1;
    adv(1);
    div_load = 1'b0;
    sync_clr = 1'b0;
    adv(2);
    chk("t4_pre_freeze_clk_out", 32'(clk_out), 0);
    en = 1'b0;
    collect(7, tv, cv);
    chk("t4_frozen_tick", 32'(tv[6:0]), 0);
    chk("t4_frozen_clk_out", 32'(cv[6:0]), 0);
    en = 1'b1;
    adv(1);
    chk("t4_resume_pos3_tick", 32'(tick), 0);
    adv(1);
    chk("t4_resume_wrap_tick", 32'(tick), 1);

    // Reset while a load is pending: asynchronous clear, pending load dropped.
    div_in   = 8'd7;
    div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("t5_pre_clk_out", 32'(clk_out), 1);
    chk("t5_pre_pending", 32'(load_pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_tick", 32'(tick), 0);
    chk("t5_async_clk_out", 32'(clk_out), 0);
    chk("t5_async_pending", 32'(load_pending), 0);
    @(negedge clk);
    rst = 1'b0;
    collect(4, tv, cv);
    chk("t5_default_div_tick", 32'(tv[3:0]), 32'b1000);
    chk("t5_default_div_clk_out", 32'(cv[3:0]), 32'b1001);

`ifdef FREQDIV_DUTY_EN
    div_in   = 8'd10;
    duty_in  = 8'd3;
    div_load = 1'b1;
    sync_clr = 1'b1;
    adv(1);
    div_load = 1'b0;
    sync_clr = 1'b0;
    collect(10, tv, cv);
    chk("t6_duty3_tick", 32'(tv[9:0]), 32'h200);
    chk("t6_duty3_clk_out", 32'(cv[9:0]), 32'h203);
    duty_in  = 8'd12;
    div_load = 1'b1;
    sync_clr = 1'b1;
    adv(1);
    div_load = 1'b0;
    sync_clr = 1'b0;
    duty_in  = 8'd0;
    collect(10, tv, cv);
    chk("t6_duty_clamp_clk_out", 32'(cv[9:0]), 32'h3FF);
`endif

    // Random traffic; inputs change just after the falling edge so async
    // reset never races the falling-edge comparison.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 9) == 0);
      div_in   = 8'($urandom_range(0, 9));
      sync_clr = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) == 0);
`ifdef FREQDIV_DUTY_EN
      duty_in  = 8'($urandom_range(0, 12));
`endif
    end
    @(negedge clk);
    #1;
    rst      = 1'b0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    adv(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_freqdiv_prog
`default_nettype wire
